instr_fetch: RTL
================

Name: instr_fetch

Overview:
Instruction fetch stage directly upstream of the cpu decode/execute core. Holds the program counter, issues reads to the synchronous instruction memory and buffers returned 16-bit commands in a small prefetch queue. Presents them to decode with a valid/ready handshake. Accepts branch redirects (JUMP taken) from execute, flushing stale prefetched words.

Parameters:
ADDR_WIDTH, 8, instruction address width; PC wraps modulo 2^ADDR_WIDTH
CMD_WIDTH, 16, command width ({opcode[15:12], f1[11:8], f2[7:4], f3[3:0]})
FIFO_DEPTH, 2, prefetch queue entries (power of two, >=2)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
imem_en  out  1  read strobe to instruction memory
imem_addr  out  ADDR_WIDTH  read address
imem_rdata  in  CMD_WIDTH  read data, valid exactly 1 cycle after imem_en
instr  out  CMD_WIDTH  command presented to decode
instr_pc  out  ADDR_WIDTH  address of instr
instr_valid  out  1  instr/instr_pc valid
instr_ready  in  1  decode accepts this cycle
redirect  in  1  taken jump, 1-cycle pulse
redirect_addr  in  ADDR_WIDTH  jump target

Behaviour:
- Reset (reset=0, async): pc=0, queue empty, inflight=0, kill=0; imem_en=0, imem_addr=0, instr_valid=0, instr=0, instr_pc=0. First request in the first cycle after release, addr 0.
- Transfer = instr_valid & instr_ready; pops queue head.
- Issue rule (no redirect): imem_en=1 when count + inflight - transfer < FIFO_DEPTH; imem_addr=pc; on issue pc<=pc+1 (0xFF -> 0x00, no overflow flag); inflight<=1, else inflight<=0.
- Return: in cycle after issue, {imem_rdata, issued addr} written to queue tail unless kill=1 (then discarded). Registered queue: issue at N, data at N+1, instr_valid high at N+2. Sustained throughput 1 command/cycle with instr_ready held 1.
- Queue full with instr_ready=0: no issue; instr, instr_pc and instr_valid held stable until transfer.
- Redirect (highest priority): queue flushed (count=0, instr_valid=0 next cycle); if inflight=1, kill<=1 so the returning word is dropped; same cycle imem_en=1, imem_addr=redirect_addr, pc<=redirect_addr+1. Transfer coinciding with redirect still counts as consumed (the jump is older); no double pop.
- Back-to-back redirects: each one wins; only the last target's words are enqueued.
- Decode does not re-sample instr after the transfer cycle; no ordering change: commands delivered strictly in address order between redirects.
- Reset asserted mid-operation: immediate return to reset values; queue contents and any in-flight word lost.
- Opcodes are not interpreted here (no predecode); stage is opcode-agnostic.

Decomposition:
- cpu_pkg: ADDR_WIDTH, CMD_WIDTH, REG_NUM, opcode constants (OP_MUL=4'b0001, OP_XNOR=4'b0010, OP_MOV=4'b0011, OP_JUMP=4'b0100, OP_LOAD=4'b0101), field slice helpers. Shared with cpu.
- Sub-module fetch_fifo: FIFO_DEPTH x (CMD_WIDTH+ADDR_WIDTH) queue with push, pop, flush, count, full/empty; async active-low reset. Fetch control (pc, inflight, kill, issue logic) stays in instr_fetch.

Test Plan:
- Stream: memory preloaded with 0x510A, 0x5214, 0x3210 at 0..2, instr_ready=1 -> imem_en in cycle 1 after reset; instr_valid from cycle 3; instr/instr_pc = 0x510A/0, 0x5214/1, 0x3210/2 on consecutive cycles.
- Backpressure: instr_ready=0 for 5 cycles -> exactly 2 words queued, imem_en=0 while full, instr=0x510A held stable; on release, no word lost or duplicated, pc order intact.
- Redirect with in-flight read: redirect=1, redirect_addr=8 while word at addr 3 in flight -> addr 3 word dropped, instr_valid=0 one cycle, next delivered instr_pc=8 (0x3520).
- Redirect coinciding with transfer: transfer of pc 5 and redirect to 8 in same cycle -> pc 5 counted once, next delivered pc=8, pc 6 never delivered.
- Wrap: redirect_addr=0xFE -> delivered pcs 0xFE, 0xFF, 0x00, 0x01.
- Reset mid-stream: reset low with 2 queued + 1 inflight -> all outputs 0 asynchronously; after release fetch restarts at addr 0.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared cpu definitions: datapath widths, opcode encodings and command field helpers.
package cpu_pkg;

  localparam int ADDR_WIDTH = 8;
  localparam int CMD_WIDTH  = 16;
  localparam int REG_NUM    = 16;
  localparam int FIFO_DEPTH = 2;

  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_XNOR = 4'b0010;
  localparam logic [3:0] OP_MOV  = 4'b0011;
  localparam logic [3:0] OP_JUMP = 4'b0100;
  localparam logic [3:0] OP_LOAD = 4'b0101;

  function automatic logic [3:0] cmd_opcode(input logic [CMD_WIDTH-1:0] cmd);
    return cmd[15:12];
  endfunction

  function automatic logic [3:0] cmd_f1(input logic [CMD_WIDTH-1:0] cmd);
    return cmd[11:8];
  endfunction

  function automatic logic [3:0] cmd_f2(input logic [CMD_WIDTH-1:0] cmd);
    return cmd[7:4];
  endfunction

  function automatic logic [3:0] cmd_f3(input logic [CMD_WIDTH-1:0] cmd);
    return cmd[3:0];
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue of {cmd, pc} entries; a flush empties it and overrides push/pop in the same cycle.
module fetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 24
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic                   flush,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    rd_ptr_r;
  logic [PW-1:0]    wr_ptr_r;
  logic [PW:0]      count_r;
  logic             full_s;
  logic             do_push_s;
  logic             do_pop_s;

  assign full_s    = (count_r == (PW+1)'(DEPTH));
  assign empty     = (count_r == {(PW+1){1'b0}});
  assign do_pop_s  = pop & ~empty;
  assign do_push_s = push & (~full_s | do_pop_s);
  assign rdata     = mem_r[rd_ptr_r];
  assign count     = count_r;

  // Storage and pointers; contents are cleared on reset so the head reads zero.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {WIDTH{1'b0}};
      end
    end else if (flush) begin
      rd_ptr_r <= {PW{1'b0}};
      wr_ptr_r <= {PW{1'b0}};
      count_r  <= {(PW+1){1'b0}};
    end else begin
      if (do_push_s) begin
        mem_r[wr_ptr_r] <= wdata;
        wr_ptr_r        <= wr_ptr_r + PTR_ONE;
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE;
      end
      count_r <= count_r + (PW+1)'(do_push_s) - (PW+1)'(do_pop_s);
    end
  end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: PC, instruction-memory requests, prefetch queue and redirect handling.
module instr_fetch #(
  parameter int ADDR_WIDTH = cpu_pkg::ADDR_WIDTH,
  parameter int CMD_WIDTH  = cpu_pkg::CMD_WIDTH,
  parameter int FIFO_DEPTH = cpu_pkg::FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  imem_en,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic [CMD_WIDTH-1:0]  imem_rdata,
  output logic [CMD_WIDTH-1:0]  instr,
  output logic [ADDR_WIDTH-1:0] instr_pc,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] redirect_addr
);

  import cpu_pkg::*;

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [ADDR_WIDTH-1:0]           pc_r;
  logic [ADDR_WIDTH-1:0]           req_addr_r;
  logic                            inflight_r;
  logic                            transfer_s;
  logic                            issue_s;
  logic                            empty_s;
  logic [CW-1:0]                   count_s;
  logic [CW:0]                     occ_s;
  logic [CMD_WIDTH+ADDR_WIDTH-1:0] head_s;

  assign transfer_s  = instr_valid & instr_ready;
  assign instr_valid = ~empty_s;
  assign instr       = head_s[CMD_WIDTH+ADDR_WIDTH-1:ADDR_WIDTH];
  assign instr_pc    = head_s[ADDR_WIDTH-1:0];
  assign imem_en     = issue_s;

  // Request decision: a redirect always fetches its target, otherwise fetch only if the word has a slot.
  always_comb begin
    occ_s     = (CW+1)'(count_s) + (CW+1)'(inflight_r);
    issue_s   = 1'b0;
    imem_addr = pc_r;
    if (!reset) begin
      issue_s   = 1'b0;
      imem_addr = {ADDR_WIDTH{1'b0}};
    end else if (redirect) begin
      issue_s   = 1'b1;
      imem_addr = redirect_addr;
    end else begin
      issue_s   = (occ_s < ((CW+1)'(FIFO_DEPTH) + (CW+1)'(transfer_s)));
      imem_addr = pc_r;
    end
  end

  // PC and in-flight tracking; the address rides along so the returning word can be tagged.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_r       <= {ADDR_WIDTH{1'b0}};
      req_addr_r <= {ADDR_WIDTH{1'b0}};
      inflight_r <= 1'b0;
    end else begin
      inflight_r <= issue_s;
      if (issue_s) begin
        req_addr_r <= imem_addr;
        pc_r       <= imem_addr + ADDR_WIDTH'(1);
      end
    end
  end

  // A stale word returns in the redirect cycle itself, so the flush (which beats push) drops it.
  fetch_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (CMD_WIDTH + ADDR_WIDTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (inflight_r),
    .pop   (transfer_s),
    .flush (redirect),
    .wdata ({imem_rdata, req_addr_r}),
    .rdata (head_s),
    .count (count_s),
    .empty (empty_s)
  );

endmodule
